oki_rom_cache: RTL and testbench

OKI_ROM_CACHE -- requirements
Module: oki_rom_cache

---
 rtl/oki_rom_cache_pkg.sv | 17 +
 rtl/oki_line_ram.sv | 33 +++
 rtl/oki_rom_cache.sv | 150 +++++++++++++++
 tb/tb_oki_rom_cache.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/oki_rom_cache_pkg.sv
// Shared constants and types for the OKI ADPCM ROM cache.
package oki_rom_cache_pkg;

    localparam int ROM_ADDR_WIDTH = 18;
    localparam int MEM_DATA_WIDTH = 16;
    localparam int DEFAULT_LINES  = 16;
    localparam int DEFAULT_BURST  = 4;

    // Cache controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        REQUEST = 2'd2,
        FILL    = 2'd3
    } state_t;

endpackage

// File: rtl/oki_line_ram.sv
// Direct-mapped line data store: one full-line write port, asynchronous byte read.
module oki_line_ram
    import oki_rom_cache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int BURST = DEFAULT_BURST,
    localparam int IDX_W     = $clog2(LINES),
    localparam int OFF_W     = $clog2(2 * BURST),
    localparam int LINE_BITS = 16 * BURST
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [LINE_BITS-1:0] wline,
    input  logic [IDX_W-1:0]     raddr,
    input  logic [OFF_W-1:0]     roff,
    output logic [7:0]           rbyte
);

    // Byte j of a line lives at bits [8*j +: 8].
    logic [LINE_BITS-1:0] mem [LINES];

    // Whole-line write; contents are only trusted behind the valid bits.
    // NOTE: data storage carries no reset; the valid bits gate every read.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wline;
        end
    end

    assign rbyte = mem[raddr][8 * int'(roff) +: 8];

endmodule

// File: rtl/oki_rom_cache.sv
// Direct-mapped read cache between the OKI sound core and the SDRAM arbiter.
module oki_rom_cache
    import oki_rom_cache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int BURST = DEFAULT_BURST
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ROM_ADDR_WIDTH-1:0] io_in_addr,
    output logic [7:0]                io_in_dout,
    output logic                      io_in_valid,
    output logic                      io_mem_rd,
    output logic [ROM_ADDR_WIDTH-1:0] io_mem_addr,
    input  logic                      io_mem_waitReq,
    input  logic                      io_mem_valid,
    input  logic [MEM_DATA_WIDTH-1:0] io_mem_dout
);

    localparam int OFF_W     = $clog2(2 * BURST);
    localparam int IDX_W     = $clog2(LINES);
    localparam int TAG_W     = ROM_ADDR_WIDTH - OFF_W - IDX_W;
    localparam int CNT_W     = $clog2(BURST) + 1;
    localparam int LINE_BITS = 16 * BURST;

    state_t                    state, state_next;
    logic [ROM_ADDR_WIDTH-1:0] addr_a;
    logic                      hit;
    logic [CNT_W-1:0]          word_cnt;
    logic [LINES-1:0]          line_valid;
    logic [TAG_W-1:0]          tag_mem [LINES];
    logic [LINE_BITS-1:0]      line_buf;
    logic [LINE_BITS-1:0]      line_next;
    logic [7:0]                ram_byte;

    // Fields of the latched address A.
    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    assign a_off = addr_a[OFF_W-1:0];
    assign a_idx = addr_a[OFF_W +: IDX_W];
    assign a_tag = addr_a[ROM_ADDR_WIDTH-1 -: TAG_W];

    logic addr_changed, lookup_hit, last_word, fill_done;
    assign addr_changed = (io_in_addr != addr_a);
    assign lookup_hit   = line_valid[a_idx] && (tag_mem[a_idx] == a_tag);
    assign last_word    = (word_cnt == CNT_W'(BURST - 1));
    assign fill_done    = (state == FILL) && io_mem_valid && last_word;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (addr_changed || !hit) state_next = LOOKUP;
            LOOKUP:  state_next = lookup_hit ? IDLE : REQUEST;
            REQUEST: if (!io_mem_waitReq) state_next = FILL;
            FILL:    if (io_mem_valid && last_word) state_next = LOOKUP;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: read strobe and the live-address valid qualifier.
    always_comb begin
        io_mem_rd   = (state == REQUEST);
        io_in_valid = (state == IDLE) && hit && !addr_changed;
    end

    // The request address is derived from A, which cannot change in REQUEST.
    assign io_mem_addr = {addr_a[ROM_ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    // Merge the incoming big-endian word into the line being assembled.
    always_comb begin
        line_next = line_buf;
        line_next[16 * int'(word_cnt) +: 16] = {io_mem_dout[7:0], io_mem_dout[15:8]};
    end

    // Control datapath: latched address, hit flag, word counter, output byte, valid bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_a     <= '0;
            hit        <= 1'b0;
            word_cnt   <= '0;
            io_in_dout <= '0;
            line_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (addr_changed || !hit) begin
                        addr_a <= io_in_addr;
                        hit    <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        io_in_dout <= ram_byte;
                        hit        <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (!io_mem_waitReq) word_cnt <= '0;
                end
                FILL: begin
                    if (io_mem_valid) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) begin
                            line_valid[a_idx] <= 1'b1;
                            addr_a            <= io_in_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags and the assembly buffer are qualified by valid bits and need no reset.
    always_ff @(posedge clock) begin
        if (state == FILL && io_mem_valid) begin
            line_buf <= line_next;
        end
        if (fill_done) begin
            tag_mem[a_idx] <= a_tag;
        end
    end

    oki_line_ram #(
        .LINES (LINES),
        .BURST (BURST)
    ) u_line_ram (
        .clock (clock),
        .we    (fill_done),
        .waddr (a_idx),
        .wline (line_next),
        .raddr (a_idx),
        .roff  (a_off),
        .rbyte (ram_byte)
    );

endmodule

// File: tb/tb_oki_rom_cache.sv
// Directed self-checking bench for oki_rom_cache with hand-computed expectations.
module tb_oki_rom_cache;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [17:0] io_in_addr = '0;
    logic [7:0]  io_in_dout;
    logic        io_in_valid;
    logic        io_mem_rd;
    logic [17:0] io_mem_addr;
    logic        io_mem_waitReq = 1'b0;
    logic        io_mem_valid = 1'b0;
    logic [15:0] io_mem_dout = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    oki_rom_cache #(.LINES(16), .BURST(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_in_addr     (io_in_addr),
        .io_in_dout     (io_in_dout),
        .io_in_valid    (io_in_valid),
        .io_mem_rd      (io_mem_rd),
        .io_mem_addr    (io_mem_addr),
        .io_mem_waitReq (io_mem_waitReq),
        .io_mem_valid   (io_mem_valid),
        .io_mem_dout    (io_mem_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Bounded wait for a read request.
    task automatic wait_rd(input string tag);
        int n = 0;
        while (!io_mem_rd && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_rd"}, 32'(io_mem_rd), 32'd1);
    endtask

    task automatic send_word(input logic [15:0] w);
        io_mem_valid = 1'b1;
        io_mem_dout  = w;
        tick();
        io_mem_valid = 1'b0;
    endtask

    // Wait for the request, check its address, step into FILL and send four words.
    task automatic fill_line(input string tag, input logic [17:0] exp_addr,
                             input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        wait_rd(tag);
        check({tag, "_addr"}, 32'(io_mem_addr), 32'(exp_addr));
        tick();
        check({tag, "_rd_drop"}, 32'(io_mem_rd), 32'd0);
        send_word(w0);
        send_word(w1);
        send_word(w2);
        send_word(w3);
    endtask

    // After the last word: LOOKUP cycle, then valid data.
    task automatic expect_data(input string tag, input logic [7:0] exp);
        check({tag, "_lookup_valid"}, 32'(io_in_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(io_in_valid), 32'd1);
        check({tag, "_dout"}, 32'(io_in_dout), 32'(exp));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        tick();
        check("rst_valid", 32'(io_in_valid), 32'd0);
        check("rst_rd", 32'(io_mem_rd), 32'd0);
        check("rst_maddr", 32'(io_mem_addr), 32'd0);
        check("rst_dout", 32'(io_in_dout), 32'd0);
        tick();
        reset = 1'b1;

        // Cold miss on 0x00123: byte 3 of line 0x120 is the low byte of word 1.
        io_in_addr = 18'h00123;
        fill_line("miss123", 18'h00120, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
        expect_data("miss123", 8'h04);

        // Hit on same line: byte 6 = high byte of word 3; valid drops at once.
        io_in_addr = 18'h00126;
        #1;
        check("hit126_drop", 32'(io_in_valid), 32'd0);
        tick();
        check("hit126_lookup_valid", 32'(io_in_valid), 32'd0);
        check("hit126_no_rd", 32'(io_mem_rd), 32'd0);
        tick();
        check("hit126_valid", 32'(io_in_valid), 32'd1);
        check("hit126_dout", 32'(io_in_dout), 32'h07);

        // Stray memory words while IDLE change nothing.
        for (int i = 0; i < 3; i++) begin
            io_mem_valid = 1'b1;
            io_mem_dout  = 16'hFFFF;
            tick();
            check("stray_valid", 32'(io_in_valid), 32'd1);
            check("stray_dout", 32'(io_in_dout), 32'h07);
            check("stray_rd", 32'(io_mem_rd), 32'd0);
        end
        io_mem_valid = 1'b0;
        io_in_addr = 18'h00123;
        tick();
        check("stray_rehit_rd", 32'(io_mem_rd), 32'd0);
        tick();
        check("stray_rehit_valid", 32'(io_in_valid), 32'd1);
        check("stray_rehit_dout", 32'(io_in_dout), 32'h04);

        // Arbiter busy for 5 cycles: request held stable.
        io_mem_waitReq = 1'b1;
        io_in_addr = 18'h00200;
        wait_rd("wait");
        for (int i = 0; i < 5; i++) begin
            check("wait_rd_hold", 32'(io_mem_rd), 32'd1);
            check("wait_addr_hold", 32'(io_mem_addr), 32'h00200);
            tick();
        end
        check("wait_rd_last", 32'(io_mem_rd), 32'd1);
        io_mem_waitReq = 1'b0;
        fill_line("wait", 18'h00200, 16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2);
        expect_data("wait", 8'hA1);
        io_in_addr = 18'h00207;
        tick();
        tick();
        check("wait_hit207_valid", 32'(io_in_valid), 32'd1);
        check("wait_hit207_dout", 32'(io_in_dout), 32'hD2);

        // Reset after the second fill word discards the partial line.
        io_in_addr = 18'h00300;
        wait_rd("rstfill");
        check("rstfill_addr", 32'(io_mem_addr), 32'h00300);
        tick();
        send_word(16'h1112);
        send_word(16'h1314);
        reset = 1'b0;
        #1;
        check("rstfill_valid", 32'(io_in_valid), 32'd0);
        check("rstfill_rd", 32'(io_mem_rd), 32'd0);
        check("rstfill_dout", 32'(io_in_dout), 32'd0);
        #2;
        reset = 1'b1;
        fill_line("refill", 18'h00300, 16'h1112, 16'h1314, 16'h1516, 16'h1718);
        expect_data("refill", 8'h11);

        // Address change mid-fill: burst completes, then the new tag is fetched.
        io_in_addr = 18'h00120;
        wait_rd("evict");
        check("evict_addr", 32'(io_mem_addr), 32'h00120);
        tick();
        send_word(16'h2122);
        send_word(16'h2324);
        io_in_addr = 18'h10120;
        check("evict_midfill_rd", 32'(io_mem_rd), 32'd0);
        send_word(16'h2526);
        send_word(16'h2728);
        fill_line("newtag", 18'h10120, 16'h5152, 16'h5354, 16'h5556, 16'h5758);
        expect_data("newtag", 8'h51);
        io_in_addr = 18'h00120;
        fill_line("evicted", 18'h00120, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
        expect_data("evicted", 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
